// File: rtl/banked_data_array_pkg.sv
// Shared types and elaboration-time helpers for the banked instruction-cache data store.
// Offsets interleave across banks: the low bits pick the bank, the high bits pick the beat.
package banked_data_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    // Field width that never collapses to zero, so single-entry dimensions still elaborate.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_of(input int words_per_line, input int num_banks);
        return words_per_line / num_banks;
    endfunction

    // Bank that holds a given word offset.
    function automatic int offset_bank(input int offset, input int num_banks);
        return offset % num_banks;
    endfunction

    // Beat (row within the line) that holds a given word offset.
    function automatic int offset_beat(input int offset, input int num_banks);
        return offset / num_banks;
    endfunction

endpackage

// File: rtl/bank_ram_1r1w.sv
// One word-wide bank: synchronous write, registered read with enable, write-first on a
// same-row collision so a reader sees the word being written in that cycle.
module bank_ram_1r1w #(
    parameter int ROW_W      = 8,
    parameter int WORD_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  we,
    input  logic [ROW_W-1:0]      waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ROW_W-1:0]      raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [2**ROW_W];

    // NOTE: the array has no reset so it maps onto RAM macros; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/banked_data_array.sv
// Instruction-cache data store: single-word reads with one-cycle latency, whole-line refills
// in beats of one word per bank, and a guard that stalls reads of not-yet-filled words.
module banked_data_array
    import banked_data_array_pkg::*;
#(
    parameter int SET_BITS_WIDTH = 4,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 16,
    parameter int NUM_BANKS      = 4,
    parameter int WORD_WIDTH     = 20,
    localparam int WAY_W         = width_of(NUM_WAYS),
    localparam int OFF_W         = width_of(WORDS_PER_LINE)
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            i_halt_all,
    input  logic [SET_BITS_WIDTH-1:0]       i_r_set_bits,
    input  logic [WAY_W-1:0]                i_r_way_index,
    input  logic [OFF_W-1:0]                i_r_word_offset,
    input  logic                            i_r_valid,
    output logic                            o_r_ready,
    input  logic [SET_BITS_WIDTH-1:0]       i_f_set_bits,
    input  logic [WAY_W-1:0]                i_f_way_index,
    input  logic [NUM_BANKS*WORD_WIDTH-1:0] i_f_data,
    input  logic                            i_f_valid,
    output logic                            o_f_ready,
    input  logic                            i_f_abort,
    output logic                            o_fill_done,
    output logic [WORD_WIDTH-1:0]           o_word_data,
    output logic                            o_valid
);

    localparam int BANK_W = width_of(NUM_BANKS);
    localparam int BEATS  = beats_of(WORDS_PER_LINE, NUM_BANKS);
    localparam int BEAT_W = width_of(BEATS);
    localparam int ROW_W  = SET_BITS_WIDTH + WAY_W + BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    fill_state_t               state, state_next;
    logic [BEAT_W-1:0]         beat_cnt, beat_cnt_next;
    logic [SET_BITS_WIDTH-1:0] fill_set, w_set;
    logic [WAY_W-1:0]          fill_way, w_way;
    logic [BEAT_W-1:0]         w_beat, r_beat;
    logic [BANK_W-1:0]         r_bank, r_bank_q;
    logic [ROW_W-1:0]          w_row, r_row;
    logic                      fill_accept, read_accept, same_line, read_blocked;
    logic [WORD_WIDTH-1:0]     bank_rdata [NUM_BANKS];

    assign r_bank = BANK_W'(offset_bank(int'(i_r_word_offset), NUM_BANKS));
    assign r_beat = BEAT_W'(offset_beat(int'(i_r_word_offset), NUM_BANKS));
    assign r_row  = {i_r_set_bits, i_r_way_index, r_beat};

    // The first beat is written straight from the request; later beats use the latched line.
    assign w_set  = (state == FILL) ? fill_set : i_f_set_bits;
    assign w_way  = (state == FILL) ? fill_way : i_f_way_index;
    assign w_beat = (state == FILL) ? beat_cnt : '0;
    assign w_row  = {w_set, w_way, w_beat};

    assign o_f_ready   = !i_halt_all && (state != DONE);
    assign fill_accept = i_f_valid && o_f_ready && !((state == FILL) && i_f_abort);

    // A word being written this cycle is readable thanks to the write-first bypass.
    assign same_line    = (state == FILL) && (i_r_set_bits == fill_set) && (i_r_way_index == fill_way);
    assign read_blocked = same_line &&
                          ((r_beat > beat_cnt) || ((r_beat == beat_cnt) && !fill_accept));
    assign o_r_ready    = !i_halt_all && !read_blocked;
    assign read_accept  = i_r_valid && o_r_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        unique case (state)
            IDLE: begin
                if (fill_accept) begin
                    beat_cnt_next = BEAT_W'(1);
                    state_next    = (BEATS == 1) ? DONE : FILL;
                end
            end
            FILL: begin
                if (i_f_abort) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else if (fill_accept) begin
                    beat_cnt_next = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            fill_set <= '0;
            fill_way <= '0;
            o_valid  <= 1'b0;
            r_bank_q <= '0;
        end else if (!i_halt_all) begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            o_valid  <= read_accept;
            if ((state == IDLE) && fill_accept) begin
                fill_set <= i_f_set_bits;
                fill_way <= i_f_way_index;
            end
            if (read_accept) begin
                r_bank_q <= r_bank;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_ram_1r1w #(
            .ROW_W      (ROW_W),
            .WORD_WIDTH (WORD_WIDTH)
        ) u_bank (
            .clk   (clk),
            .arst  (arst),
            .we    (fill_accept),
            .waddr (w_row),
            .wdata (i_f_data[b*WORD_WIDTH +: WORD_WIDTH]),
            .re    (read_accept && (r_bank == BANK_W'(b))),
            .raddr (r_row),
            .rdata (bank_rdata[b])
        );
    end

    // Only the addressed bank's read register moves, so the selected word holds between reads.
    assign o_word_data = bank_rdata[r_bank_q];
    assign o_fill_done = (state == DONE);

endmodule

// File: doc/banked_data_array.md
Name: banked_data_array

Overview:
Parametrised instruction-cache data store built from NUM_BANKS interleaved 1R1W word banks. It serves single-word reads with 1-cycle latency and accepts whole-line refills as a sequence of multi-word beats under a fill state machine. It guards reads against not-yet-written words of the line being filled and forwards same-cycle write data. It sits between the tag/hit logic (read side) and the refill/memory interface (fill side).

Parameters:
SET_BITS_WIDTH, 4, set index width
NUM_WAYS, 4, associativity (power of 2)
WORDS_PER_LINE, 16, words per cache line (power of 2, multiple of NUM_BANKS)
NUM_BANKS, 4, interleaved banks; one beat = one word per bank
WORD_WIDTH, 20, instruction word width
Derived: WAY_W=clog2(NUM_WAYS), OFF_W=clog2(WORDS_PER_LINE), BANK_W=clog2(NUM_BANKS), BEATS=WORDS_PER_LINE/NUM_BANKS, BEAT_W=max(1,clog2(BEATS)), ROW_W=SET_BITS_WIDTH+WAY_W+BEAT_W

Ports:
clk  in  1  clock
arst  in  1  reset; one clock; reset is asynchronous and active-high
i_halt_all  in  1  global freeze
i_r_set_bits  in  SET_BITS_WIDTH  read set
i_r_way_index  in  WAY_W  read way
i_r_word_offset  in  OFF_W  word within line
i_r_valid  in  1  read request
o_r_ready  out  1  read accepted when i_r_valid&o_r_ready
i_f_set_bits  in  SET_BITS_WIDTH  fill set, sampled on first beat
i_f_way_index  in  WAY_W  fill way, sampled on first beat
i_f_data  in  NUM_BANKS*WORD_WIDTH  beat data; bank b = bits [b*WORD_WIDTH +: WORD_WIDTH]
i_f_valid  in  1  beat valid
o_f_ready  out  1  beat accepted when i_f_valid&o_f_ready
i_f_abort  in  1  abandon current fill
o_fill_done  out  1  1-cycle pulse after last beat written
o_word_data  out  WORD_WIDTH  read data
o_valid  out  1  o_word_data valid

Behaviour:
- Address map: bank = offset[BANK_W-1:0]; row = {set, way, offset[OFF_W-1:BANK_W]}.
- Reset (arst high, async): FSM=IDLE, beat_cnt=0, o_valid=0, o_word_data=0, o_fill_done=0, fill set/way regs=0. Bank contents are not reset.
- i_halt_all=1: o_r_ready=0, o_f_ready=0. No state, bank, or output register changes; outputs hold.
- Fill FSM:
  - IDLE: o_f_ready=1. An accepted beat latches set/way, writes beat 0 to all banks, and goes to FILL with beat_cnt=1. If BEATS==1, it goes directly to DONE.
  - FILL: o_f_ready=1. Each accepted beat writes row beat=beat_cnt and increments beat_cnt. When the beat with beat_cnt==BEATS-1 is accepted, go to DONE.
  - DONE: o_fill_done=1 for exactly one cycle; o_f_ready=0; then IDLE with beat_cnt=0.
  - i_f_abort in FILL: go to IDLE with beat_cnt=0; a beat presented in the same cycle is not written. Abort in IDLE/DONE is ignored.
- Read guard: o_r_ready=0 when FSM=FILL, read set/way == fill set/way, and read beat >= beat_cnt. A read of a beat being written in the same cycle is allowed. Otherwise o_r_ready=~i_halt_all.
- Read latency: 1 cycle. o_valid(t+1) = accepted read at t; o_valid is otherwise 0 on non-halted edges.
- o_word_data updates only on accepted reads; it holds its last value otherwise.
- Same-cycle write/read to the same bank row: write-first. o_word_data returns the new beat word.
- Simultaneous last beat and read of another line: both proceed.

Decomposition:
- Package banked_data_array_pkg: fill_state_t enum {IDLE, FILL, DONE}, derived width functions, and the address-split helper.
- Sub-module bank_ram_1r1w: behavioural ROWS×WORD_WIDTH, synchronous write, registered read with read-enable, write-first bypass. NUM_BANKS instances are generated.
- The top level holds the FSM, guard, and output mux. The bank select is registered alongside the read.

Test Plan:
1. Reset/idle: assert arst mid-cycle -> o_valid=0, o_word_data=0, o_f_ready=1 immediately; deassert, no requests -> o_valid stays 0.
2. Full fill then read: fill set 3, way 2, beats k with bank b word = 16'h100+4k+b -> o_fill_done pulses 1 cycle after the 4th beat. Read offset 9 -> o_valid next cycle with data 0x109.
3. Read guard: mid-fill with beat_cnt=2, read same line offset 12 -> o_r_ready=0 until beat 3 is written. Read offset 5 -> accepted, data 0x105. Read of another line -> accepted.
4. Write-first: read offset 4 of the fill line in the same cycle beat 1 is written -> o_word_data = beat 1 bank 0 new value.
5. Halt: assert i_halt_all for 3 cycles during FILL with i_f_valid=1 -> o_f_ready=0, beat_cnt unchanged, o_word_data/o_valid held; release -> fill resumes and completes.
6. Abort/reset mid-fill: i_f_abort after beat 1 -> IDLE, no o_fill_done. A new fill to way 0 completes normally. Repeat the fill with arst after beat 2 -> FSM IDLE, o_fill_done never asserts.
